neuron_accumulator: RTL and testbench

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

---
 rtl/neuron_acc_pkg.sv | 17 +
 rtl/neuron_accumulator_shift_sat.sv | 36 +++
 rtl/neuron_accumulator.sv | 102 ++++++++++
 tb/tb_neuron_accumulator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_acc_pkg.sv
`default_nettype none
// neuron_acc_pkg -- shared FSM state type and accumulator sizing for neuron_accumulator (rev 1.0).
package neuron_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Headroom bits cover fan_in full-precision products plus the shifted bias.
  function automatic int acc_width(input int width, input int fan_in);
    return 2 * width + $clog2(fan_in + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_accumulator_shift_sat.sv
`default_nettype none
// acc_shift_sat -- floor shift of the accumulator by frac_bits, then saturate or wrap to width (rev 1.0).
// Optional: NEURON_ACC_SATURATE_EN selects clamping; otherwise two's-complement wrap.
module acc_shift_sat #(
  parameter int in_width  = 28,
  parameter int width     = 12,
  parameter int frac_bits = 8
) (
  input  logic [in_width-1:0] sum,
  output logic [width-1:0]    z
);

  logic signed [in_width-1:0] shifted;

  assign shifted = $signed(sum) >>> frac_bits;

`ifdef NEURON_ACC_SATURATE_EN
  localparam logic signed [in_width-1:0] MAX_V = {{(in_width-width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [in_width-1:0] MIN_V = {{(in_width-width+1){1'b1}}, {(width-1){1'b0}}};

  always_comb begin
    z = shifted[width-1:0];
    if (shifted > MAX_V)
      z = MAX_V[width-1:0];
    else if (shifted < MIN_V)
      z = MIN_V[width-1:0];
  end
`else
  logic unused_hi;

  assign z         = shifted[width-1:0];
  assign unused_hi = ^shifted[in_width-1:width];
`endif

endmodule
`default_nettype wire

// File: rtl/neuron_accumulator.sv
`default_nettype none
// neuron_accumulator -- bias + sum of fan_in signed act*wt products, emitted as a fixed-point z (rev 1.0).
// Optional: NEURON_ACC_SATURATE_EN (handled inside acc_shift_sat).
module neuron_accumulator
  import neuron_acc_pkg::*;
#(
  parameter int width     = 12,
  parameter int frac_bits = 8,
  parameter int fan_in    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] bias_in,
  input  logic             in_valid,
  input  logic [width-1:0] act_in,
  input  logic [width-1:0] wt_in,
  output logic             in_ready,
  output logic [width-1:0] z_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int ACC_W = acc_width(width, fan_in);
  localparam int CNT_W = $clog2(fan_in + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(fan_in - 1);

  state_t state, state_next;

  logic signed [ACC_W-1:0]   acc;
  logic        [CNT_W-1:0]   cnt;
  logic        [width-1:0]   z_reg;

  logic signed [2*width-1:0] product;
  logic signed [ACC_W-1:0]   product_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   sum;
  logic        [width-1:0]   z_next;
  logic                      accept;
  logic                      last;
  logic                      load;

  assign product     = $signed(act_in) * $signed(wt_in);
  assign product_ext = {{(ACC_W-2*width){product[2*width-1]}}, product};
  assign bias_ext    = {{(ACC_W-width){bias_in[width-1]}}, bias_in} <<< frac_bits;
  assign sum         = acc + product_ext;

  assign accept = in_valid && (state == ACCUM);
  assign last   = accept && (cnt == LAST_CNT);
  // A new neuron may start from IDLE or in the same cycle DONE hands off its result.
  assign load   = start && ((state == IDLE) || ((state == DONE) && out_ready));

  acc_shift_sat #(
    .in_width  (ACC_W),
    .width     (width),
    .frac_bits (frac_bits)
  ) u_shift_sat (
    .sum (sum),
    .z   (z_next)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = start ? ACCUM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      cnt   <= '0;
      z_reg <= '0;
    end else if (load) begin
      acc <= bias_ext;
      cnt <= '0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt + CNT_W'(1);
      if (last)
        z_reg <= z_next;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign z_out     = z_reg;

endmodule
`default_nettype wire

// File: tb/tb_neuron_accumulator.sv
`default_nettype none
// tb_neuron_accumulator -- scoreboard bench for neuron_accumulator (fan_in=4 and fan_in=1 instances).
module tb_neuron_accumulator;

  localparam int W = 12;
  localparam int F = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, in_valid, out_ready;
  logic [W-1:0] bias_in, act_in, wt_in;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] z_out;

  logic         s1_start, s1_valid, s1_oready;
  logic [W-1:0] s1_bias, s1_act, s1_wt;
  logic         s1_iready, s1_ovalid, s1_busy;
  logic [W-1:0] s1_z;

  neuron_accumulator #(.width(W), .frac_bits(F), .fan_in(N)) dut (
    .clk(clk), .reset(reset), .start(start), .bias_in(bias_in),
    .in_valid(in_valid), .act_in(act_in), .wt_in(wt_in), .in_ready(in_ready),
    .z_out(z_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  neuron_accumulator #(.width(W), .frac_bits(F), .fan_in(1)) dut1 (
    .clk(clk), .reset(reset), .start(s1_start), .bias_in(s1_bias),
    .in_valid(s1_valid), .act_in(s1_act), .wt_in(s1_wt), .in_ready(s1_iready),
    .z_out(s1_z), .out_valid(s1_ovalid), .out_ready(s1_oready), .busy(s1_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ta[N];
  logic [W-1:0] tw[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] bias);
    longint s, sh, b;
    b = longint'($signed(bias));
    s = b <<< F;
    for (int i = 0; i < N; i++)
      s += longint'($signed(ta[i])) * longint'($signed(tw[i]));
    sh = s >>> F;
`ifdef NEURON_ACC_SATURATE_EN
    if (sh > 64'sd2047) sh = 64'sd2047;
    if (sh < -64'sd2048) sh = -64'sd2048;
`endif
    return sh[W-1:0];
  endfunction

  task automatic set_all(input logic [W-1:0] a, input logic [W-1:0] w);
    for (int i = 0; i < N; i++) begin
      ta[i] = a;
      tw[i] = w;
    end
  endtask

  task automatic begin_neuron(input logic [W-1:0] b);
    start   = 1'b1;
    bias_in = b;
    tick();
    start = 1'b0;
    check("in_ready_after_start", in_ready, 1);
  endtask

  task automatic feed(input int spurious);
    for (int i = 0; i < N; i++) begin
      act_in   = ta[i];
      wt_in    = tw[i];
      in_valid = 1'b1;
      if (i == spurious) begin
        start   = 1'b1;
        bias_in = 12'h7FF;
      end
      check("in_ready_accum", in_ready, 1);
      if (i == N - 1) check("out_valid_early", out_valid, 0);
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
    end
    check("out_valid_latency", out_valid, 1);
  endtask

  task automatic collect();
    logic [W-1:0] e;
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) check("out_valid_timeout", out_valid, 1);
    e = exp_q.pop_front();
    check("z_out", z_out, e);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("busy_after_handshake", busy, 0);
  endtask

  task automatic run(input logic [W-1:0] b, input logic [W-1:0] e, input int sp);
    exp_q.push_back(e);
    begin_neuron(b);
    feed(sp);
    collect();
  endtask

  initial begin
    logic [W-1:0] rb;
    logic [W-1:0] e;
    reset = 1'b1; start = 1'b0; bias_in = '0; in_valid = 1'b0;
    act_in = '0; wt_in = '0; out_ready = 1'b0;
    s1_start = 1'b0; s1_bias = '0; s1_valid = 1'b0; s1_act = '0; s1_wt = '0; s1_oready = 1'b0;
    tick();
    tick();
    check("rst_z_out", z_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_dut1_busy", s1_busy, 0);
    reset = 1'b0;
    tick();

    // Basic, negative, and floor truncation
    set_all(12'h100, 12'h100);
    run(12'h000, 12'h400, -1);
    set_all(12'h100, 12'hF00);
    run(12'h000, 12'hC00, -1);
    set_all(12'h000, 12'h000);
    ta[0] = 12'h001;
    tw[0] = 12'hFFF;
    run(12'h000, 12'hFFF, -1);

    // Overflow of the shifted sum: clamp or wrap
    set_all(12'h7FF, 12'h7FF);
`ifdef NEURON_ACC_SATURATE_EN
    run(12'h7FF, 12'h7FF, -1);
`else
    run(12'h7FF, 12'h7BF, -1);
`endif
    set_all(12'h7FF, 12'h800);
`ifdef NEURON_ACC_SATURATE_EN
    run(12'h000, 12'h800, -1);
`else
    run(12'h000, 12'h020, -1);
`endif

    // Random neurons; the second also pulses start mid-accumulation
    for (int r = 0; r < 3; r++) begin
      rb = W'($urandom);
      for (int i = 0; i < N; i++) begin
        ta[i] = W'($urandom);
        tw[i] = W'($urandom);
      end
      run(rb, model(rb), (r == 1) ? 1 : -1);
    end

    // Backpressure in DONE, then back-to-back start with handshake
    set_all(12'h100, 12'h100);
    e = 12'h480;
    begin_neuron(12'h080);
    feed(-1);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      act_in   = 12'h7FF;
      wt_in    = 12'h7FF;
      start    = 1'b1;
      tick();
      check("hold_z_out", z_out, e);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    bias_in   = 12'h100;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("restart_in_ready", in_ready, 1);
    check("restart_out_valid", out_valid, 0);
    exp_q.push_back(12'h500);
    feed(-1);
    collect();

    // Reset after two accepted pairs, with competing inputs asserted
    set_all(12'h7FF, 12'h7FF);
    begin_neuron(12'h123);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      act_in   = ta[i];
      wt_in    = tw[i];
      tick();
    end
    reset     = 1'b1;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("midrst_z_out", z_out, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    set_all(12'h100, 12'h100);
    run(12'h000, 12'h400, -1);

    // fan_in = 1: a single pair completes the neuron
    s1_start = 1'b1;
    s1_bias  = 12'h100;
    tick();
    s1_start = 1'b0;
    check("fan1_in_ready", s1_iready, 1);
    s1_valid = 1'b1;
    s1_act   = 12'h200;
    s1_wt    = 12'h180;
    tick();
    s1_valid = 1'b0;
    check("fan1_out_valid", s1_ovalid, 1);
    check("fan1_z_out", s1_z, 12'h400);
    s1_oready = 1'b1;
    tick();
    s1_oready = 1'b0;
    check("fan1_busy", s1_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
